// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, requester IDs and arbitration types for the regfile write-back arbiter.
package regfile_wb_arbiter_pkg;

`ifdef CUSTOM_DEFINE
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
    localparam int unsigned DEF_REG_WIDTH      = `REG_WIDTH;
    localparam int unsigned DEF_REG_ADDR_WIDTH = `REG_ADDR_WIDTH;
`else
    localparam int unsigned DEF_REG_WIDTH      = 32;
    localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
`endif

    localparam int unsigned DEF_CNT_WIDTH = 16;

    // Requester IDs, also used as bit indices into the request/grant vectors.
    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LSU  = 1;
    localparam int unsigned NUM_REQS = 2;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: a lone request always wins, ties go to the
// requester not granted most recently.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    output logic [NUM_REQS-1:0] gnt_c
);

    pri_e ptr_q;
    pri_e ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= PRI_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer moves only on a grant and then favours the other requester.
    always_comb begin
        gnt_c = '0;
        ptr_d = ptr_q;
        if (req[REQ_ALU] && (!req[REQ_LSU] || (ptr_q == PRI_ALU))) begin
            gnt_c[REQ_ALU] = 1'b1;
            ptr_d          = PRI_LSU;
        end else if (req[REQ_LSU]) begin
            gnt_c[REQ_LSU] = 1'b1;
            ptr_d          = PRI_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between ALU and LSU: one registered regfile write per cycle,
// bypass hit detection for decode and a saturating arbitration-conflict counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = regfile_wb_arbiter_pkg::DEF_REG_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = regfile_wb_arbiter_pkg::DEF_REG_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH      = regfile_wb_arbiter_pkg::DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_addr,
    input  logic [REG_WIDTH-1:0]      alu_data,

    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_addr,
    input  logic [REG_WIDTH-1:0]      lsu_data,

    output logic                      RegWEn,
    output logic [REG_ADDR_WIDTH-1:0] addrD,
    output logic [REG_WIDTH-1:0]      dataD,

    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_hit,
    output logic                      rs2_hit,

    output logic [CNT_WIDTH-1:0]      conflict_cnt
);

    logic [NUM_REQS-1:0]       req;
    logic [NUM_REQS-1:0]       gnt_c;
    logic                      grant_c;
    logic                      conflict_c;
    logic [REG_ADDR_WIDTH-1:0] sel_addr_c;
    logic [REG_WIDTH-1:0]      sel_data_c;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_LSU] = lsu_valid;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt_c (gnt_c)
    );

    assign alu_ready  = gnt_c[REQ_ALU];
    assign lsu_ready  = gnt_c[REQ_LSU];
    assign grant_c    = |gnt_c;
    assign conflict_c = alu_valid && lsu_valid;

    // Payload of the granted requester; only meaningful when grant_c is set.
    always_comb begin
        sel_addr_c = alu_addr;
        sel_data_c = alu_data;
        if (gnt_c[REQ_LSU]) begin
            sel_addr_c = lsu_addr;
            sel_data_c = lsu_data;
        end
    end

    // Output stage: x0 writes are accepted but never enabled; idle cycles hold addr/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWEn <= 1'b0;
            addrD  <= '0;
            dataD  <= '0;
        end else begin
            RegWEn <= grant_c && (sel_addr_c != '0);
            if (grant_c) begin
                addrD <= sel_addr_c;
                dataD <= sel_data_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (conflict_c && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

    assign rs1_hit = RegWEn && (addrD == rs1_addr) && (rs1_addr != '0);
    assign rs2_hit = RegWEn && (addrD == rs2_addr) && (rs2_addr != '0);

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter REG_WIDTH, default 32, register data width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter CNT_WIDTH, default 16, width of the conflict counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alu_valid  input  1  ALU write-back request; held until accepted.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 alu_addr  input  REG_ADDR_WIDTH  ALU destination register.
REQ-009 alu_data  input  REG_WIDTH  ALU write data.
REQ-010 lsu_valid  input  1  load-unit write-back request; held until accepted.
REQ-011 lsu_ready  output  1  LSU request accepted this cycle.
REQ-012 lsu_addr  input  REG_ADDR_WIDTH  LSU destination register.
REQ-013 lsu_data  input  REG_WIDTH  LSU write data.
REQ-014 RegWEn  output  1  regfile write enable, registered.
REQ-015 addrD  output  REG_ADDR_WIDTH  regfile write address, registered.
REQ-016 dataD  output  REG_WIDTH  regfile write data, registered.
REQ-017 rs1_addr / rs2_addr  input  REG_ADDR_WIDTH  decode-stage read addresses.
REQ-018 rs1_hit / rs2_hit  output  1  the staged write targets that read address (bypass select).
REQ-019 conflict_cnt  output  CNT_WIDTH  saturating count of cycles where a request lost arbitration.

Function
REQ-020 ready signals SHALL be combinational from the valid inputs and the priority pointer, and at most one of alu_ready/lsu_ready SHALL be high in any cycle.
REQ-021 A lone valid request SHALL be granted in the same cycle regardless of the pointer.
REQ-022 When both requests are valid, the grant SHALL go to the requester not granted most recently (round-robin), so no requester waits more than one grant.
REQ-023 The pointer SHALL update only on a grant and SHALL then favour the other requester.
REQ-024 A granted request SHALL appear on addrD/dataD exactly one cycle later (latency 1), with RegWEn high.
REQ-025 A granted request with address 0 SHALL be accepted (ready high), but RegWEn SHALL stay low that next cycle; addrD/dataD still update.
REQ-026 In a cycle with no grant, RegWEn SHALL be 0 the next cycle; addrD/dataD SHALL hold their values.
REQ-027 rsN_hit SHALL be RegWEn AND (addrD == rsN_addr) AND (rsN_addr != 0), combinational.
REQ-028 conflict_cnt SHALL increment by 1 in each cycle where both valids are high, and SHALL saturate at all-ones without wrapping.
REQ-029 A requester dropping valid without being granted is a protocol violation; behaviour is unspecified but the output stage SHALL never write data it did not grant.

Reset
REQ-030 While reset is high: RegWEn=0, addrD=0, dataD=0, conflict_cnt=0, pointer favours ALU; ready outputs stay combinational.
REQ-031 Reset asserted mid-operation SHALL discard the staged write (RegWEn=0 immediately); requests not yet granted stay pending at the requesters.
REQ-032 The first grant after reset deassertion SHALL follow REQ-021/REQ-022 with ALU favoured.

Structure
REQ-033 REG_WIDTH and REG_ADDR_WIDTH SHALL come from the shared defines.vh when CUSTOM_DEFINE is set; requester-ID constants REQ_ALU=0 and REQ_LSU=1 SHALL also live there.
REQ-034 The two-input round-robin grant logic and its pointer SHALL be a sub-module rr_arb2; the output stage, hit logic and counter SHALL stay in the top module.

Verification
REQ-035 After reset, alu_valid=1, addr=1, data=255 for one cycle -> alu_ready=1 that cycle; next cycle RegWEn=1, addrD=1, dataD=255.
REQ-036 alu and lsu both valid (addr 2/data 254, addr 3/data 7) held -> ALU granted first, LSU the next cycle; writes appear on consecutive cycles; conflict_cnt=1.
REQ-037 lsu_valid only, addr=0, data=32'hFFFF -> lsu_ready=1; next cycle RegWEn=0; regfile x0 reads 0.
REQ-038 Staged write addr=5 with rs1_addr=5, rs2_addr=0 -> rs1_hit=1, rs2_hit=0; with rs2_addr=0 and addrD=0 -> rs2_hit=0.
REQ-039 Both valid continuously for 2^CNT_WIDTH+3 cycles -> grants alternate every cycle and conflict_cnt stays at all-ones.
REQ-040 Reset pulsed while RegWEn=1 -> RegWEn drops without waiting for clk; after release a still-valid request is granted and written one cycle later.
